icache_rd_bridge: RTL and testbench

ICACHE_RD_BRIDGE -- requirements
Module: icache_rd_bridge

---
 rtl/icache_rd_bridge_if.sv | 44 ++++
 rtl/icache_rd_bridge.sv | 139 +++++++++++++
 tb/tb_icache_rd_bridge.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_rd_bridge_if.sv
// Bundle of the icache-side read port and the AXI read channels (AR and R).
// The slave view belongs to the bridge itself. The master view belongs to the
// environment, which drives the icache requests and the AXI memory responses.
interface icache_rd_bridge_if;
  // icache side
  logic         i_arvalid;
  logic [31:0]  i_araddr;
  logic         i_uncached;
  logic         i_arready;
  logic         i_rvalid;
  logic [31:0]  i_rdata;
  logic         i_rlast;
  logic         i_rready;
  logic [127:0] fill_line;
  logic         fill_valid;
  logic         rd_err;
  // AXI AR channel
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  // AXI R channel
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  modport slave (
    input  i_arvalid, i_araddr, i_uncached, i_rready,
    input  arready, rdata, rresp, rlast, rvalid,
    output i_arready, i_rvalid, i_rdata, i_rlast, fill_line, fill_valid, rd_err,
    output araddr, arlen, arsize, arburst, arvalid, rready
  );

  modport master (
    output i_arvalid, i_araddr, i_uncached, i_rready,
    output arready, rdata, rresp, rlast, rvalid,
    input  i_arready, i_rvalid, i_rdata, i_rlast, fill_line, fill_valid, rd_err,
    input  araddr, arlen, arsize, arburst, arvalid, rready
  );
endinterface

// File: rtl/icache_rd_bridge.sv
// Instruction-cache read bridge. It turns one icache request into one AXI INCR
// read burst. An uncached request is a single word. A cached request is a
// 4-word line. Returned beats pass through a one-entry output buffer. Cached
// beats are also assembled into fill_line.
module icache_rd_bridge (
  input  logic              clk,
  input  logic              rstn,
  icache_rd_bridge_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAddr = 2'd1;
  localparam logic [1:0] StData = 2'd2;

  logic [1:0]   state_q, state_d;
  logic         live_q;
  logic [31:0]  addr_q;
  logic         uncached_q;
  logic [1:0]   cnt_q;
  logic         buf_valid_q;
  logic [31:0]  buf_data_q;
  logic         buf_last_q;
  logic [127:0] fill_line_q;
  logic         fill_valid_q;
  logic         rd_err_q;

  logic         req_fire;
  logic         ar_fire;
  logic         beat_fire;
  logic         out_fire;
  logic         beat_last;
  logic [1:0]   last_idx;

  // The beat count, not AXI rlast, decides which beat ends the burst.
  assign last_idx  = uncached_q ? 2'd0 : 2'd3;
  assign beat_last = (cnt_q == last_idx);

  // live_q keeps i_arready low during reset and releases it on the first edge after.
  assign bus.i_arready = live_q && (state_q == StIdle) && !buf_valid_q;
  assign req_fire      = bus.i_arvalid && bus.i_arready;

  assign bus.arvalid = (state_q == StAddr);
  assign ar_fire     = bus.arvalid && bus.arready;
  assign bus.araddr  = bus.arvalid ? addr_q : 32'd0;
  assign bus.arlen   = bus.arvalid ? {6'd0, last_idx} : 8'd0;
  assign bus.arsize  = bus.arvalid ? 3'b010 : 3'b000;
  assign bus.arburst = bus.arvalid ? 2'b01 : 2'b00;

  // Accept a beat when the buffer is empty or is being drained in the same cycle.
  assign bus.rready = (state_q == StData) && (!buf_valid_q || bus.i_rready);
  assign beat_fire  = bus.rvalid && bus.rready;
  assign out_fire   = buf_valid_q && bus.i_rready;

  assign bus.i_rvalid   = buf_valid_q;
  assign bus.i_rdata    = buf_data_q;
  assign bus.i_rlast    = buf_valid_q && buf_last_q;
  assign bus.fill_line  = fill_line_q;
  assign bus.fill_valid = fill_valid_q;
  assign bus.rd_err     = rd_err_q;

  // Next-state logic for the IDLE -> ADDR -> DATA request sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (req_fire) state_d = StAddr;
      StAddr:  if (ar_fire) state_d = StData;
      StData:  if (beat_fire && beat_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register and post-reset enable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  // Latch the request and keep count of the accepted beats.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q     <= 32'd0;
      uncached_q <= 1'b0;
      cnt_q      <= 2'd0;
    end else if (req_fire) begin
      addr_q     <= bus.i_araddr;
      uncached_q <= bus.i_uncached;
      cnt_q      <= 2'd0;
    end else if (beat_fire && !beat_last) begin
      cnt_q <= cnt_q + 2'd1;
    end
  end

  // One-entry output buffer. A load has priority over a drain, so a beat can
  // enter while the previous one leaves.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_valid_q <= 1'b0;
      buf_data_q  <= 32'd0;
      buf_last_q  <= 1'b0;
    end else if (beat_fire) begin
      buf_valid_q <= 1'b1;
      buf_data_q  <= bus.rdata;
      buf_last_q  <= beat_last;
    end else if (out_fire) begin
      buf_valid_q <= 1'b0;
    end
  end

  // Assemble the cached line. The pulse lines up with the last beat on i_rvalid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fill_line_q  <= 128'd0;
      fill_valid_q <= 1'b0;
    end else begin
      if (beat_fire && !uncached_q) begin
        fill_line_q[{cnt_q, 5'd0} +: 32] <= bus.rdata;
      end
      fill_valid_q <= beat_fire && beat_last && !uncached_q;
    end
  end

  // Sticky error flag. It is set by a bad response or by an rlast that disagrees
  // with the count, and it is cleared when a new request is accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_err_q <= 1'b0;
    end else if (req_fire) begin
      rd_err_q <= 1'b0;
    end else if (beat_fire && ((bus.rresp != 2'b00) || (bus.rlast != beat_last))) begin
      rd_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_icache_rd_bridge.sv
// Testbench for icache_rd_bridge. It runs directed scenarios and then random
// requests. A transaction-level model predicts the returned beats, the error
// flag and the assembled line.
module tb_icache_rd_bridge;

  logic clk = 1'b0;
  logic rstn;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  icache_rd_bridge_if bus ();

  icache_rd_bridge dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Stimulus for the next request, plus model state.
  logic [31:0]  beat_data [4];
  logic [1:0]   beat_resp [4];
  bit   [3:0]   beat_badlast;
  int           hold_beat;
  int           span;
  logic [127:0] fill_model;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {bus.i_arready, bus.i_rvalid, bus.i_rlast, bus.fill_valid, bus.rd_err,
                          bus.arvalid, bus.rready}, 0);
    check({tag, "_dat"}, {bus.i_rdata, bus.araddr, bus.arlen, bus.arsize, bus.arburst}, 0);
    check({tag, "_line"}, bus.fill_line, 0);
  endtask

  // One complete request: issue it, check the AR phase, then serve the R beats
  // and consume the outputs concurrently.
  task automatic run_req(input logic [31:0] addr, input bit unc, input int stall,
                         input int bp_pct, input int gap_pct);
    int  nb;
    int  guard;
    bit  errs [4];
    bit  exp_err;
    nb = unc ? 1 : 4;
    for (int k = 0; k < 4; k++) errs[k] = (beat_resp[k] != 2'b00) || beat_badlast[k];

    guard = 0;
    @(negedge clk);
    while (!bus.i_arready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready", bus.i_arready, 1);
    bus.i_arvalid  = 1'b1;
    bus.i_araddr   = addr;
    bus.i_uncached = unc;
    @(negedge clk);
    bus.i_arvalid  = 1'b0;
    bus.i_araddr   = $urandom;
    bus.i_uncached = 1'($urandom);

    for (int c = 0; c <= stall; c++) begin
      check("arvalid", bus.arvalid, 1);
      check("araddr", bus.araddr, addr);
      check("arlen", bus.arlen, unc ? 0 : 3);
      check("arsize_burst", {bus.arsize, bus.arburst}, {3'b010, 2'b01});
      check("ar_busy", bus.i_arready, 0);
      check("err_clr", bus.rd_err, 0);
      if (c == stall) bus.arready = 1'b1;
      @(negedge clk);
    end
    bus.arready = 1'b0;
    check("ar_zero", {bus.arvalid, bus.araddr, bus.arlen, bus.arsize, bus.arburst}, 0);

    span = 0;
    fork
      begin : axi_side
        for (int k = 0; k < nb; k++) begin
          int g;
          g = 0;
          while ($urandom_range(99) < gap_pct) begin
            bus.rvalid = 1'b0;
            @(negedge clk);
          end
          bus.rvalid = 1'b1;
          bus.rdata  = beat_data[k];
          bus.rresp  = beat_resp[k];
          bus.rlast  = (k == nb - 1) ^ beat_badlast[k];
          #1;
          while (!bus.rready && g < 200) begin
            @(negedge clk);
            #1;
            g++;
          end
          if (g >= 200) check("axi_timeout", 0, 1);
          @(negedge clk);
        end
        bus.rvalid = 1'b0;
      end
      begin : icache_side
        int got;
        int fv;
        int g;
        int held;
        int acc;
        got = 0; fv = 0; g = 0; held = 0;
        while (got < nb && g < 400) begin
          if (got == hold_beat && bus.i_rvalid && held < 3) begin
            bus.i_rready = 1'b0;
            held++;
          end else begin
            bus.i_rready = ($urandom_range(99) >= bp_pct);
          end
          #1;
          // Beats taken from AXI so far = beats consumed + the one in the buffer.
          acc = got + (bus.i_rvalid ? 1 : 0);
          exp_err = 1'b0;
          for (int k = 0; k < acc; k++) exp_err |= errs[k];
          check("rd_err", bus.rd_err, exp_err);
          if (bus.i_rvalid || span > 0) span++;
          if (bus.i_rvalid) begin
            check("i_rdata", bus.i_rdata, beat_data[got]);
            check("i_rlast", bus.i_rlast, got == nb - 1);
            if (!bus.i_rready) check("rready_full", bus.rready, 0);
          end
          if (bus.fill_valid) begin
            fv++;
            check("fv_with_last", bus.i_rvalid && bus.i_rlast, 1);
          end
          if (bus.i_rvalid && bus.i_rready) got++;
          @(negedge clk);
          g++;
        end
        bus.i_rready = 1'b0;
        check("beats", got, nb);
        check("fill_pulses", fv, unc ? 0 : 1);
      end
    join

    if (!unc) for (int k = 0; k < 4; k++) fill_model[32*k +: 32] = beat_data[k];
    exp_err = 1'b0;
    for (int k = 0; k < nb; k++) exp_err |= errs[k];
    check("fill_line", bus.fill_line, fill_model);
    check("err_hold", bus.rd_err, exp_err);
    check("idle_ready", bus.i_arready, 1);
    hold_beat = -1;
  endtask

  task automatic clean_beats();
    for (int k = 0; k < 4; k++) begin
      beat_data[k] = $urandom;
      beat_resp[k] = 2'b00;
    end
    beat_badlast = 4'b0000;
  endtask

  initial begin
    logic [31:0] a;
    bit          u;
    rstn = 1'b0;
    bus.i_arvalid = 1'b0; bus.i_araddr = 32'd0; bus.i_uncached = 1'b0; bus.i_rready = 1'b0;
    bus.arready = 1'b0; bus.rdata = 32'd0; bus.rresp = 2'b00; bus.rlast = 1'b0;
    bus.rvalid = 1'b0;
    hold_beat = -1;
    fill_model = 128'd0;
    span = 0;

    // Reset state, then release
    #1 check_zero("reset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1 check("rel_not_ready", bus.i_arready, 0);
    @(negedge clk);
    check("rel_ready", bus.i_arready, 1);

    // R beats arriving while idle are ignored
    bus.rvalid = 1'b1; bus.rdata = 32'h1234_5678; bus.rlast = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("idle_rready", bus.rready, 0);
      check("idle_no_out", bus.i_rvalid, 0);
      @(negedge clk);
    end
    bus.rvalid = 1'b0;
    check("idle_still_ready", bus.i_arready, 1);

    // Cached line, full throughput
    clean_beats();
    for (int k = 0; k < 4; k++) beat_data[k] = 32'hA0 + k;
    run_req(32'h1C00_0010, 1'b0, 0, 0, 0);
    check("hit_span", span, 4);
    check("hit_line", bus.fill_line, 128'h000000A3_000000A2_000000A1_000000A0);

    // Uncached single word; the line must keep its previous contents
    clean_beats();
    beat_data[0] = 32'h55;
    run_req(32'hBFD0_F004, 1'b1, 0, 0, 0);
    check("unc_line_kept", bus.fill_line, 128'h000000A3_000000A2_000000A1_000000A0);

    // AR stall of 5 cycles
    clean_beats();
    run_req(32'h0000_4560, 1'b0, 5, 0, 0);

    // Backpressure: beat 1 held for 3 cycles while rvalid stays high
    clean_beats();
    hold_beat = 1;
    run_req(32'h0000_7770, 1'b0, 0, 0, 0);

    // Error response on beat 2; all beats are still delivered
    clean_beats();
    beat_resp[2] = 2'b10;
    run_req(32'h0000_8880, 1'b0, 1, 20, 20);

    // Reset in the middle of a burst
    @(negedge clk);
    bus.i_arvalid = 1'b1; bus.i_araddr = 32'h0000_1230; bus.i_uncached = 1'b0;
    @(negedge clk);
    bus.i_arvalid = 1'b0; bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0; bus.i_rready = 1'b0;
    bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_0000; bus.rresp = 2'b00; bus.rlast = 1'b0;
    @(negedge clk);
    bus.rdata = 32'hDEAD_0001;
    check("rst_pre_valid", bus.i_rvalid, 1);
    #2 rstn = 1'b0;
    #1 check_zero("rst_mid");
    @(negedge clk);
    check_zero("rst_hold");
    bus.rvalid = 1'b0;
    rstn = 1'b1;
    fill_model = 128'd0;
    #1 check("rst_rel_not_ready", bus.i_arready, 0);
    @(negedge clk);
    check("rst_rel_ready", bus.i_arready, 1);
    clean_beats();
    run_req(32'h1FC0_0008, 1'b1, 0, 0, 0);

    // Random requests
    for (int t = 0; t < 30; t++) begin
      u = 1'($urandom);
      a = $urandom;
      a = u ? (a & ~32'h3) : (a & ~32'hF);
      for (int k = 0; k < 4; k++) begin
        beat_data[k] = $urandom;
        beat_resp[k] = ($urandom_range(99) < 10) ? 2'($urandom_range(3, 1)) : 2'b00;
      end
      beat_badlast = 4'b0000;
      for (int k = 0; k < 4; k++) beat_badlast[k] = ($urandom_range(99) < 8);
      hold_beat = ($urandom_range(3) == 0) ? int'($urandom_range(3)) : -1;
      run_req(a, u, int'($urandom_range(3)), int'($urandom_range(60)),
              int'($urandom_range(50)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
